// File: rtl/led_scan_ctrl.sv
// HUB75 panel scan sequencer: per row, shifts each BCM plane from the framebuffer, then latches and lights it for BASE_TIME<<plane cycles.
// Optional build macro LED_SCAN_BRIGHTNESS_EN adds a brightness input that shortens the lit part of every DISPLAY period.
module led_scan_ctrl #(
  parameter int COL_BITS  = 5,
  parameter int ROW_BITS  = 4,
  parameter int PLANES    = 4,
  parameter int BASE_TIME = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [7:0]                   brightness,
`endif
  output logic [ROW_BITS+COL_BITS-1:0] rd_addr,
  input  logic [3*PLANES-1:0]          rd_data,
  output logic                         r,
  output logic                         g,
  output logic                         b,
  output logic                         sclk,
  output logic                         lat,
  output logic                         oe_n,
  output logic [ROW_BITS-1:0]          row_addr,
  output logic                         frame_start,
  output logic                         busy
);

  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int DW = $clog2((BASE_TIME << (PLANES - 1)) + 1);
  localparam int AW = ROW_BITS + COL_BITS;
  localparam logic [COL_BITS-1:0] COL_LAST   = '1;
  localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;
  localparam logic [PW-1:0]       PLANE_LAST = PW'(PLANES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFETCH, S_SHIFT_LO, S_SHIFT_HI, S_BLANK, S_LATCH, S_DISPLAY
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [COL_BITS-1:0]   r_col, w_col_nxt;
  logic [ROW_BITS-1:0]   r_row, w_row_nxt;
  logic [PW-1:0]         r_plane, w_plane_nxt;
  logic [DW-1:0]         r_dcnt, w_dcnt_nxt;
  logic [AW-1:0]         r_rd_addr, w_rd_addr_nxt;
  logic                  r_r, r_g, r_b, w_r_nxt, w_g_nxt, w_b_nxt;
  logic                  r_sclk, r_lat, r_oe_n, r_frame_start, r_busy;
  logic                  w_sclk_nxt, w_lat_nxt, w_oe_n_nxt, w_frame_start_nxt, w_busy_nxt;
  logic [ROW_BITS-1:0]   r_row_addr, w_row_addr_nxt;

  logic [DW-1:0]         w_dur;
  logic                  w_disp_done;
  logic [PLANES-1:0]     w_r_bits, w_g_bits, w_b_bits;
  logic                  w_oe_entry, w_oe_disp;

  assign w_dur       = DW'(BASE_TIME) << r_plane;
  assign w_disp_done = (r_dcnt == w_dur - DW'(1));
  assign {w_r_bits, w_g_bits, w_b_bits} = rd_data;

`ifdef LED_SCAN_BRIGHTNESS_EN
  // Lit length is fixed for the whole DISPLAY period from the brightness seen on entry.
  logic [DW-1:0] r_lit, w_lit;

  assign w_lit      = DW'(((DW+8)'(w_dur) * ((DW+8)'(brightness) + (DW+8)'(1))) >> 8);
  assign w_oe_entry = (w_lit == '0);
  assign w_oe_disp  = ((r_dcnt + DW'(1)) >= r_lit);

  always_ff @(posedge clk) begin
    if (rst)                    r_lit <= '0;
    else if (r_state == S_LATCH) r_lit <= w_lit;
  end
`else
  assign w_oe_entry = 1'b0;
  assign w_oe_disp  = 1'b0;
`endif

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (enable) w_state_nxt = S_PREFETCH;
      S_PREFETCH: w_state_nxt = S_SHIFT_LO;
      S_SHIFT_LO: w_state_nxt = S_SHIFT_HI;
      S_SHIFT_HI: w_state_nxt = (r_col == COL_LAST) ? S_BLANK : S_SHIFT_LO;
      S_BLANK:    w_state_nxt = S_LATCH;
      S_LATCH:    w_state_nxt = S_DISPLAY;
      S_DISPLAY:  if (w_disp_done) w_state_nxt = enable ? S_PREFETCH : S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_col_nxt         = r_col;
    w_row_nxt         = r_row;
    w_plane_nxt       = r_plane;
    w_dcnt_nxt        = r_dcnt;
    w_rd_addr_nxt     = r_rd_addr;
    w_r_nxt           = r_r;
    w_g_nxt           = r_g;
    w_b_nxt           = r_b;
    w_row_addr_nxt    = r_row_addr;
    w_sclk_nxt        = 1'b0;
    w_lat_nxt         = 1'b0;
    w_oe_n_nxt        = 1'b1;
    w_frame_start_nxt = 1'b0;
    w_busy_nxt        = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: if (enable) begin
        w_row_nxt         = '0;
        w_plane_nxt       = '0;
        w_col_nxt         = '0;
        w_rd_addr_nxt     = '0;
        w_frame_start_nxt = 1'b1;
      end
      S_PREFETCH: w_col_nxt = '0;
      S_SHIFT_LO: w_sclk_nxt = 1'b1;
      S_SHIFT_HI: if (r_col != COL_LAST) w_col_nxt = r_col + 1'b1;
      S_BLANK: begin
        w_lat_nxt      = 1'b1;
        w_row_addr_nxt = r_row;
      end
      S_LATCH: begin
        w_dcnt_nxt = '0;
        w_oe_n_nxt = w_oe_entry;
      end
      S_DISPLAY: begin
        if (!w_disp_done) begin
          w_dcnt_nxt = r_dcnt + 1'b1;
          w_oe_n_nxt = w_oe_disp;
        end else if (!enable) begin
          w_row_nxt   = '0;
          w_plane_nxt = '0;
        end else begin
          w_col_nxt = '0;
          if (r_plane != PLANE_LAST) begin
            w_plane_nxt = r_plane + 1'b1;
          end else begin
            w_plane_nxt       = '0;
            w_row_nxt         = r_row + 1'b1;
            w_frame_start_nxt = (r_row == ROW_LAST);
          end
          w_rd_addr_nxt = {w_row_nxt, {COL_BITS{1'b0}}};
        end
      end
      default: ;
    endcase
    // Data changes only as sclk falls; the read address runs one column ahead and saturates.
    if (w_state_nxt == S_SHIFT_LO) begin
      w_r_nxt       = w_r_bits[r_plane];
      w_g_nxt       = w_g_bits[r_plane];
      w_b_nxt       = w_b_bits[r_plane];
      w_rd_addr_nxt = {r_row, (w_col_nxt == COL_LAST) ? COL_LAST : w_col_nxt + 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col         <= '0;
      r_row         <= '0;
      r_plane       <= '0;
      r_dcnt        <= '0;
      r_rd_addr     <= '0;
      r_r           <= 1'b0;
      r_g           <= 1'b0;
      r_b           <= 1'b0;
      r_row_addr    <= '0;
      r_sclk        <= 1'b0;
      r_lat         <= 1'b0;
      r_oe_n        <= 1'b1;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_plane       <= w_plane_nxt;
      r_dcnt        <= w_dcnt_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
      r_r           <= w_r_nxt;
      r_g           <= w_g_nxt;
      r_b           <= w_b_nxt;
      r_row_addr    <= w_row_addr_nxt;
      r_sclk        <= w_sclk_nxt;
      r_lat         <= w_lat_nxt;
      r_oe_n        <= w_oe_n_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign rd_addr     = r_rd_addr;
  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;
  assign sclk        = r_sclk;
  assign lat         = r_lat;
  assign oe_n        = r_oe_n;
  assign row_addr    = r_row_addr;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl: a position-in-frame reference model predicts every output each cycle.
// Builds with or without LED_SCAN_BRIGHTNESS_EN.
module tb_led_scan_ctrl;

  localparam int COL_BITS  = 5;
  localparam int ROW_BITS  = 4;
  localparam int PLANES    = 4;
  localparam int BASE_TIME = 8;
  localparam int NC        = 1 << COL_BITS;
  localparam int NR        = 1 << ROW_BITS;
  localparam int SHIFT_LEN = 1 + 2 * NC;

  logic        clk = 1'b0;
  logic        rst, enable;
`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [7:0]  brightness;
  int          m_bright;
`endif
  logic [8:0]  rd_addr;
  logic [11:0] rd_data;
  logic        r, g, b, sclk, lat, oe_n, frame_start, busy;
  logic [3:0]  row_addr;

  logic [11:0] fb [NC*NR];
  assign rd_data = fb[rd_addr];

  led_scan_ctrl #(
    .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_TIME(BASE_TIME)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef LED_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .rd_addr(rd_addr), .rd_data(rd_data),
    .r(r), .g(g), .b(b), .sclk(sclk), .lat(lat), .oe_n(oe_n),
    .row_addr(row_addr), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ROW_LEN, FRAME_LEN;

  // Reference model state: running flag, cycle offset in the frame, and the values the panel holds.
  bit         m_run;
  int         m_t;
  logic [8:0] m_rd_addr;
  logic [2:0] m_rgb;
  logic [3:0] m_row_addr;

  int         cyc = 0;
  logic       prev_sclk = 1'b0;
  logic [2:0] prev_rgb = 3'b000;
  int         low_run = 0;
  int         last_fs = -1;
  int         q_low[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int plane_len(input int p);
    return SHIFT_LEN + 2 + (BASE_TIME << p);
  endfunction

  // Lit cycles of a DISPLAY period for plane p.
  function automatic int on_cycles(input int p);
`ifdef LED_SCAN_BRIGHTNESS_EN
    return ((BASE_TIME << p) * (m_bright + 1)) >> 8;
`else
    return BASE_TIME << p;
`endif
  endfunction

  function automatic void locate(input int t, output int row, output int plane, output int off);
    int u;
    u     = t % FRAME_LEN;
    row   = u / ROW_LEN;
    u     = u % ROW_LEN;
    plane = 0;
    while (u >= plane_len(plane)) begin
      u -= plane_len(plane);
      plane++;
    end
    off = u;
  endfunction

  task automatic model_expect(output logic [20:0] e);
    int row, p, off, c;
    logic [11:0] px;
    logic s, l, o, f;
    s = 1'b0; l = 1'b0; o = 1'b1; f = 1'b0;
    if (m_run) begin
      locate(m_t, row, p, off);
      if (off == 0) begin
        m_rd_addr = 9'(row * NC);
        f = (row == 0 && p == 0);
      end else if (off <= 2 * NC) begin
        c = (off - 1) / 2;
        m_rd_addr = 9'(row * NC + ((c + 1 < NC) ? c + 1 : NC - 1));
        px = fb[row * NC + c];
        m_rgb = {px[2*PLANES+p], px[PLANES+p], px[p]};
        s = ((off - 1) % 2) == 1;
      end else if (off == SHIFT_LEN + 1) begin
        l = 1'b1;
        m_row_addr = 4'(row);
      end else if (off >= SHIFT_LEN + 2) begin
        o = (off - SHIFT_LEN - 2) >= on_cycles(p);
      end
    end
    e = {m_rd_addr, m_rgb, s, l, o, m_row_addr, f, m_run};
  endtask

  // Advance the model across the coming clock edge using the inputs now driven.
  task automatic model_advance();
    int row, p, off;
    if (rst) begin
      m_run = 1'b0; m_rd_addr = '0; m_rgb = '0; m_row_addr = '0;
    end else if (!m_run) begin
      if (enable) begin m_run = 1'b1; m_t = 0; end
    end else begin
      locate(m_t, row, p, off);
`ifdef LED_SCAN_BRIGHTNESS_EN
      if (off == SHIFT_LEN + 1) m_bright = brightness;
`endif
      if (off == plane_len(p) - 1 && !enable) m_run = 1'b0;
      else m_t++;
    end
  endtask

  task automatic tick();
    logic [20:0] e, got;
    int row, p, off;
    model_advance();
    @(negedge clk);
    cyc++;
    model_expect(e);
    got = {rd_addr, r, g, b, sclk, lat, oe_n, row_addr, frame_start, busy};
    check("outputs", 32'(got), 32'(e));
    if (prev_sclk === 1'b0 && sclk === 1'b1) check("sclk_setup", {r, g, b}, prev_rgb);
    if (oe_n === 1'b0) low_run++;
    else begin
      if (low_run > 0) q_low.push_back(low_run);
      low_run = 0;
    end
    if (!m_run) last_fs = -1;
    else if (frame_start === 1'b1) begin
      if (last_fs >= 0) check("fs_period", cyc - last_fs, FRAME_LEN);
      last_fs = cyc;
    end
    if (m_run) begin
      locate(m_t, row, p, off);
      if (row == 3 && off == 16) begin
        if (p == 0)               check("px37_p0", {r, g, b}, 3'b001);
        else if (p == PLANES - 1) check("px37_p3", {r, g, b}, 3'b110);
      end
    end
    prev_sclk = sclk;
    prev_rgb  = {r, g, b};
  endtask

  initial begin
    int found, low, target, row, p, off;
    ROW_LEN = 0;
    for (int i = 0; i < PLANES; i++) ROW_LEN += plane_len(i);
    FRAME_LEN = NR * ROW_LEN;
    for (int i = 0; i < NC * NR; i++) fb[i] = 12'($urandom);
    fb[3 * NC + 7] = 12'h8A5;
    m_run = 1'b0; m_t = 0; m_rd_addr = '0; m_rgb = '0; m_row_addr = '0;
    rst = 1'b1; enable = 1'b0;
`ifdef LED_SCAN_BRIGHTNESS_EN
    brightness = 8'd127; m_bright = 127;
`endif

    repeat (3) tick();
    check("rst_oe_n", oe_n, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_lat_sclk", {lat, sclk}, 0);
    rst = 1'b0;
    repeat (2) tick();

    enable = 1'b1;
    tick();
    check("start_fs", frame_start, 1);
    check("start_busy", busy, 1);
    q_low.delete();
    low_run = 0;
    for (int i = 0; i < FRAME_LEN + 20; i++) tick();

    check("low_count", q_low.size(), NR * PLANES);
    for (int i = 0; i < q_low.size() && i < NR * PLANES; i++)
      check("low_width", q_low[i], on_cycles(i % PLANES));

    // Drop enable in the middle of a plane-2 shift.
    target = $urandom_range(1, 2 * NC);
    found  = 0;
    for (int i = 0; i < 2 * ROW_LEN && found == 0; i++) begin
      locate(m_t, row, p, off);
      if (m_run && p == 2 && off == target) found = 1;
      else tick();
    end
    check("find_p2", found, 1);
    enable = 1'b0;
    found  = 0;
    low    = 0;
    for (int i = 0; i < ROW_LEN && found == 0; i++) begin
      tick();
      if (oe_n === 1'b0) low++;
      if (!m_run) found = 1;
    end
    check("drop_idle", found, 1);
    check("drop_lit", low, on_cycles(2));
    check("drop_busy", busy, 0);
    check("drop_oe_n", oe_n, 1);
    repeat (4) tick();

    enable = 1'b1;
    tick();
    check("re_fs", frame_start, 1);
    check("re_rd_addr", rd_addr, 0);
    for (int i = 0; i < 2 * ROW_LEN; i++) begin
`ifdef LED_SCAN_BRIGHTNESS_EN
      brightness = (i < ROW_LEN) ? 8'd0 : 8'($urandom_range(0, 255));
`endif
      tick();
    end

    // Reset while lit.
    found = 0;
    for (int i = 0; i < ROW_LEN && found == 0; i++) begin
      locate(m_t, row, p, off);
      if (m_run && off >= SHIFT_LEN + 2 + $urandom_range(0, 3)) found = 1;
      else tick();
    end
    check("find_disp", found, 1);
    rst = 1'b1;
    tick();
    check("rstd_oe_n", oe_n, 1);
    check("rstd_lat", lat, 0);
    check("rstd_sclk", sclk, 0);
    check("rstd_row_addr", row_addr, 0);
    check("rstd_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 500; i++) begin
`ifdef LED_SCAN_BRIGHTNESS_EN
      brightness = 8'($urandom_range(0, 255));
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Sequencer that drives a HUB75-style RGB LED matrix from a pixel framebuffer.
- For each row it runs every bit plane in turn: shift one column-bit per pixel, blank, latch, then light for a binary-weighted time (binary code modulation).
- Sits between the framebuffer RAM read port and the panel pins.
- Internally built from flex-counter-style column, row, plane and display-time counters.

Parameters:
- COL_BITS, 5: log2 of columns per row (32 columns).
- ROW_BITS, 4: log2 of scanned rows (16 rows).
- PLANES, 4: colour bits per channel, which is the number of BCM planes.
- BASE_TIME, 8: lit cycles for plane 0. Plane p is lit for BASE_TIME<<p cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  run scanning.
- rd_addr  out  ROW_BITS+COL_BITS  framebuffer address {row,col}.
- rd_data  in  3*PLANES  pixel {r,g,b}, valid one cycle after rd_addr.
- r, g, b  out  1 each  current plane bit of the pixel.
- sclk  out  1  panel shift clock.
- lat  out  1  panel latch.
- oe_n  out  1  panel output enable, active low.
- row_addr  out  ROW_BITS  displayed row.
- frame_start  out  1  one-cycle pulse at the start of each frame.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: state=IDLE; rd_addr=0; r=g=b=0; sclk=0; lat=0; oe_n=1; row_addr=0; frame_start=0; busy=0; row, plane and column counters all 0.
- Reset asserted mid-operation forces these values on the next edge. No partial plane is completed.
- IDLE: oe_n=1. When enable=1, go to PREFETCH with row=0 and plane=0, and pulse frame_start.
- PREFETCH (1 cycle): rd_addr={row,0}. Go to SHIFT_LO with col=0.
- SHIFT_LO (1 cycle):
  - On entry edge, load r/g/b from rd_data bit `plane` of each channel, set sclk=0, and set rd_addr={row,col+1}.
  - rd_addr saturates at the last column, so no out-of-row read occurs.
  - Go to SHIFT_HI.
- SHIFT_HI (1 cycle): sclk=1, data held. If col==2^COL_BITS-1, go to BLANK; else col+1 and go to SHIFT_LO.
- Shift phase length: 1+2*2^COL_BITS cycles (65 at defaults).
- Data stability: data changes only when sclk falls; sclk rises only with data already stable for one cycle.
- BLANK (1 cycle): sclk=0, oe_n=1.
- LATCH (1 cycle): lat=1, row_addr<=row. lat returns to 0 on exit.
- DISPLAY: oe_n=0 for exactly BASE_TIME<<plane cycles, then oe_n=1 on exit.
- Exit from DISPLAY, in priority order:
  1. enable=0: go to IDLE. Row and plane are reset to 0.
  2. plane<PLANES-1: plane+1, go to PREFETCH.
  3. Otherwise plane=0 and row+1, go to PREFETCH. The row wraps from 2^ROW_BITS-1 to 0; on wrap, frame_start pulses on the PREFETCH entry edge.
- enable is sampled only in IDLE and at the end of DISPLAY. Deasserting it elsewhere never truncates a plane.
- Cycle budget at defaults:
  - Plane time: 67+(BASE_TIME<<p) cycles.
  - Row: 4*67+120=388 cycles.
  - Frame: 16*388=6208 cycles.
- The display-time counter is wide enough for BASE_TIME<<(PLANES-1) without overflow.

Optional Feature:
- Macro: LED_SCAN_BRIGHTNESS_EN.
- When defined:
  - Adds input brightness[7:0], sampled on DISPLAY entry.
  - DISPLAY length is unchanged, but oe_n=0 only for the first (dur*(brightness+1))>>8 cycles, where dur=BASE_TIME<<plane. oe_n=1 for the remainder.
  - brightness=255 gives full duration. brightness=0 with plane 0 gives zero lit cycles.
- When not defined: no brightness port, and oe_n=0 for all of DISPLAY.

Test Plan:
- Reset, then enable=1: frame_start pulses once; 65 shift cycles; 32 sclk rising edges; lat high 1 cycle; oe_n low 8 cycles; row_addr=0.
- Framebuffer pixel (row 3, col 7)=0x8A5 ({r=1000,g=1010,b=0101}): col 7 shows r,g,b=0,0,1 on plane 0 and r,g,b=1,1,0 on plane 3 (and r,g,b=1,1,0 on plane 3); data stable across each sclk rising edge.
- Full frame: oe_n low widths cycle 8,16,32,64; row_addr steps 0..15 and then wraps to 0; frame_start period is 6208 cycles.
- Drop enable during plane 2 SHIFT: plane 2 completes its 32-cycle DISPLAY, then IDLE with oe_n=1 and busy=0. Re-enable: restarts at row 0, plane 0, with frame_start.
- Assert rst during DISPLAY: next edge gives oe_n=1, lat=0, sclk=0, row_addr=0, IDLE.
- LED_SCAN_BRIGHTNESS_EN with brightness=127: plane 3 lit 32 of 64 cycles, plane 0 lit 4 of 8; brightness=0 with plane 0 gives oe_n high throughout.
